// File: rtl/hls_deadlock_monitor_gen.sv
// ---------------------------------------------------------------------------
// hls_deadlock_monitor_gen
//
// Purpose: watches the block indications coming out of an HLS design (AXI
// stream FIFOs and sub-instance idle/block pairs) and raises a registered
// deadlock flag once a raw block condition has persisted for HOLD_CYCLES
// consecutive clock edges. The sources active at detection time are kept
// for post-mortem inspection.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   axis_block_sigs  per-stream block indications            [N_AXIS]
//   axis_mask        1 excludes that stream from detection    [N_AXIS]
//   inst_idle_sigs   per-instance idle indications            [N_INST]
//   inst_block_sigs  per-instance block indications           [N_INST]
//   clear            single-cycle request to return to IDLE
//   block            registered deadlock flag
//   block_pulse      one-cycle strobe on the cycle block rises
//   cause_axis       unmasked stream blocks captured at detection
//   cause_inst       instance blocks captured at detection
//   hold_count       current persistence count
//   state_dbg        FSM state (0 IDLE, 1 PENDING, 2 BLOCKED)
// ---------------------------------------------------------------------------
module hls_deadlock_monitor_gen #(
    parameter int N_AXIS      = 4,
    parameter int N_INST      = 1,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 16,
    parameter int STICKY      = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_AXIS-1:0] axis_mask,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              block_pulse,
    output logic [N_AXIS-1:0] cause_axis,
    output logic [N_INST-1:0] cause_inst,
    output logic [CNT_W-1:0]  hold_count,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state_q;
    logic                block_q;
    logic                pulse_q;
    logic [N_AXIS-1:0]   cause_axis_q;
    logic [N_INST-1:0]   cause_inst_q;
    logic [CNT_W-1:0]    hold_q;

    logic [N_AXIS-1:0]   axis_live_d;
    logic                inst_deadlock_d;
    logic                raw_d;
    logic [CNT_W-1:0]    hold_inc_d;

    // An instance group is deadlocked when nobody is doing useful work
    // (each is idle or blocked) and at least one is actually blocked;
    // all-idle is just a quiescent design.
    always_comb begin
        axis_live_d     = axis_block_sigs & ~axis_mask;
        inst_deadlock_d = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
        raw_d           = (|axis_live_d) | inst_deadlock_d;
        hold_inc_d      = hold_q + CNT_ONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            block_q      <= 1'b0;
            pulse_q      <= 1'b0;
            cause_axis_q <= '0;
            cause_inst_q <= '0;
            hold_q       <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (clear) begin
                state_q      <= ST_IDLE;
                block_q      <= 1'b0;
                cause_axis_q <= '0;
                cause_inst_q <= '0;
                hold_q       <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (raw_d) begin
                            if (HOLD_CYCLES == 1) begin
                                state_q      <= ST_BLOCKED;
                                block_q      <= 1'b1;
                                pulse_q      <= 1'b1;
                                cause_axis_q <= axis_live_d;
                                cause_inst_q <= inst_block_sigs;
                                hold_q       <= HOLD_VAL;
                            end else begin
                                state_q <= ST_PENDING;
                                hold_q  <= CNT_ONE;
                            end
                        end else begin
                            hold_q <= '0;
                        end
                    end
                    ST_PENDING: begin
                        if (raw_d) begin
                            if (hold_inc_d == HOLD_VAL) begin
                                state_q      <= ST_BLOCKED;
                                block_q      <= 1'b1;
                                pulse_q      <= 1'b1;
                                cause_axis_q <= axis_live_d;
                                cause_inst_q <= inst_block_sigs;
                                hold_q       <= HOLD_VAL;
                            end else begin
                                hold_q <= hold_inc_d;
                            end
                        end else begin
                            // Any gap restarts the count from zero.
                            state_q <= ST_IDLE;
                            hold_q  <= '0;
                        end
                    end
                    ST_BLOCKED: begin
                        // Non-sticky mode self-clears but keeps the cause
                        // registers so software can still see what fired.
                        if ((STICKY == 0) && !raw_d) begin
                            state_q <= ST_IDLE;
                            block_q <= 1'b0;
                            hold_q  <= '0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        block_q <= 1'b0;
                        hold_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign block       = block_q;
    assign block_pulse = pulse_q;
    assign cause_axis  = cause_axis_q;
    assign cause_inst  = cause_inst_q;
    assign hold_count  = hold_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/hls_deadlock_monitor_gen.md
HLS_DEADLOCK_MONITOR_GEN -- requirements
Module: hls_deadlock_monitor_gen

Interface
REQ-001 SHALL have parameter N_AXIS, default 4: number of AXI-stream block inputs, range 1..32.
REQ-002 SHALL have parameter N_INST, default 1: number of sub-instance idle/block pairs, range 1..32.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16: consecutive raw-block cycles required before `block` asserts, range 1..2^CNT_W-1.
REQ-004 SHALL have parameter CNT_W, default 16: width of the persistence counter.
REQ-005 SHALL have parameter STICKY, default 1: 1 means `block` latches until `clear`; 0 means `block` self-clears.
REQ-006 SHALL have port clock, input, 1: rising-edge clock; the block SHALL use no other clock.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port axis_block_sigs, input, N_AXIS: per-stream block indications.
REQ-009 SHALL have port axis_mask, input, N_AXIS: 1 excludes the corresponding stream from detection.
REQ-010 SHALL have port inst_idle_sigs, input, N_INST: per-instance idle indications.
REQ-011 SHALL have port inst_block_sigs, input, N_INST: per-instance block indications.
REQ-012 SHALL have port clear, input, 1: single-cycle request to return to IDLE.
REQ-013 SHALL have port block, output, 1: registered deadlock flag.
REQ-014 SHALL have port block_pulse, output, 1: one-cycle strobe on the cycle `block` rises.
REQ-015 SHALL have port cause_axis, output, N_AXIS: unmasked axis_block_sigs captured at detection.
REQ-016 SHALL have port cause_inst, output, N_INST: inst_block_sigs captured at detection.
REQ-017 SHALL have port hold_count, output, CNT_W: current persistence count.

Function
REQ-018 SHALL compute combinational raw = (|(axis_block_sigs & ~axis_mask)) | (inst_deadlock).
REQ-019 SHALL define inst_deadlock = every instance has idle or block set AND at least one instance has block set.
REQ-020 SHALL implement FSM states IDLE, PENDING, BLOCKED; reset state IDLE.
REQ-021 In IDLE with raw=1: if HOLD_CYCLES=1, go to BLOCKED; else go to PENDING with hold_count=1.
REQ-022 In IDLE with raw=0: stay in IDLE, hold_count=0.
REQ-023 In PENDING with raw=1 and hold_count+1=HOLD_CYCLES: go to BLOCKED.
REQ-024 In PENDING with raw=1 otherwise: increment hold_count.
REQ-025 In PENDING with raw=0: go to IDLE, hold_count=0; there is no partial-credit accumulation.
REQ-026 On entry to BLOCKED: block=1 and block_pulse=1 for exactly one cycle; cause_axis/cause_inst load the values sampled on the transition edge; hold_count holds at HOLD_CYCLES.
REQ-027 In BLOCKED with STICKY=1: remain in BLOCKED regardless of raw until clear.
REQ-028 In BLOCKED with STICKY=0 and raw=0: go to IDLE with block=0; cause registers keep their last values.
REQ-029 When clear=1 in any state: next state IDLE, block=0, hold_count=0, cause registers zeroed; clear has priority over raw on the same cycle.
REQ-030 block SHALL rise exactly HOLD_CYCLES clock edges after the first edge at which raw is sampled high continuously; HOLD_CYCLES=1 gives one-cycle registered latency.
REQ-031 Changes to axis_mask SHALL take effect on the next edge; masking a stream while in PENDING SHALL drop raw and return the FSM to IDLE if no other source is active.

Reset
REQ-032 While reset=1 on a rising edge: state=IDLE, block=0, block_pulse=0, hold_count=0, cause_axis=0, cause_inst=0.
REQ-033 Reset SHALL have priority over clear and raw; reset mid-PENDING or in BLOCKED SHALL discard all progress.

Verification
REQ-034 Scenario: HOLD_CYCLES=4, axis_block_sigs=4'b0100 held -> block=1 on the 4th edge, block_pulse high 1 cycle, cause_axis=4'b0100.
REQ-035 Scenario: HOLD_CYCLES=4, raw high 3 cycles, low 1 cycle, high 4 cycles -> no block after the first burst; block on the 4th edge of the second burst.
REQ-036 Scenario: STICKY=1, block set, raw dropped -> block stays 1; clear pulse -> block=0 and cause_axis=0 next cycle.
REQ-037 Scenario: N_INST=2, inst_idle=2'b01, inst_block=2'b10 held HOLD_CYCLES cycles -> block=1, cause_inst=2'b10; with inst_idle=2'b00 instead -> no block.
REQ-038 Scenario: axis_mask=4'b0001, axis_block_sigs=4'b0001 held -> block stays 0 and hold_count=0.
REQ-039 Scenario: reset asserted in PENDING at hold_count=3 -> hold_count=0 and block=0 next edge; clear and raw asserted together in PENDING -> state IDLE.
